dual_sw_scheduler: RTL and testbench

//  Control sequencer for the two-stopwatch display. Takes debounced one-cycle button

---
 rtl/stopwatch_pkg.sv | 82 ++++++++
 rtl/sw_channel_fsm.sv | 48 ++++
 rtl/dual_sw_scheduler.sv | 117 +++++++++++
 tb/tb_dual_sw_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the two-stopwatch control sequencer:
//   - sw_state_e     : per-channel run/pause/split state encoding (3 bits)
//   - LED_*_BIT      : bit positions inside a 3-bit status LED word
//   - sw_next_state  : channel transition rule (clr > trig > split priority)
//   - sw_led_word    : builds one channel's status LED word
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RUN         = 3'd1,
        ST_PAUSE       = 3'd2,
        ST_RUN_SPLIT   = 3'd3,
        ST_PAUSE_SPLIT = 3'd4
    } sw_state_e;

    localparam int unsigned LED_W         = 3;
    localparam int unsigned LED_CNT_BIT   = 0;
    localparam int unsigned LED_SPLIT_BIT = 1;
    localparam int unsigned LED_SEL_BIT   = 2;

    // Next state of one channel for the pulses steered to it this cycle.
    // Lower-priority pulses are dropped when a higher one is present.
    function automatic sw_state_e sw_next_state(input sw_state_e cur,
                                                input logic      trig,
                                                input logic      split,
                                                input logic      clr);
        sw_state_e nxt;
        nxt = cur;
        if (clr) begin
            nxt = ST_IDLE;
        end else if (trig) begin
            case (cur)
                ST_IDLE:        nxt = ST_RUN;
                ST_RUN:         nxt = ST_PAUSE;
                ST_PAUSE:       nxt = ST_RUN;
                ST_RUN_SPLIT:   nxt = ST_PAUSE_SPLIT;
                ST_PAUSE_SPLIT: nxt = ST_RUN_SPLIT;
                default:        nxt = ST_IDLE;
            endcase
        end else if (split) begin
            case (cur)
                ST_RUN:         nxt = ST_RUN_SPLIT;
                ST_RUN_SPLIT:   nxt = ST_RUN;
                ST_PAUSE_SPLIT: nxt = ST_PAUSE;
                ST_IDLE:        nxt = ST_IDLE;   // split ignored
                ST_PAUSE:       nxt = ST_PAUSE;  // split ignored
                default:        nxt = ST_IDLE;
            endcase
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    function automatic logic sw_is_counting(input sw_state_e s);
        return (s == ST_RUN) || (s == ST_RUN_SPLIT);
    endfunction

    function automatic logic sw_is_split(input sw_state_e s);
        return (s == ST_RUN_SPLIT) || (s == ST_PAUSE_SPLIT);
    endfunction

    function automatic logic sw_is_paused(input sw_state_e s);
        return (s == ST_PAUSE) || (s == ST_PAUSE_SPLIT);
    endfunction

    // Status LEDs: [0] counting, or blink phase while paused; [1] split; [2] selected.
    function automatic logic [LED_W-1:0] sw_led_word(input sw_state_e s,
                                                     input logic      selected,
                                                     input logic      blink);
        logic [LED_W-1:0] w;
        w                = {LED_W{1'b0}};
        w[LED_CNT_BIT]   = sw_is_counting(s) | (sw_is_paused(s) & blink);
        w[LED_SPLIT_BIT] = sw_is_split(s);
        w[LED_SEL_BIT]   = selected;
        return w;
    endfunction

endpackage

// File: rtl/sw_channel_fsm.sv
// -----------------------------------------------------------------------------
// sw_channel_fsm
// One stopwatch channel: state register plus registered count/split/clear
// decode. Pulses arriving here have already been steered to this channel.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   i_trig/i_split/i_clr  steered one-cycle pulses
//   o_state_nxt       state the channel moves to at this edge (for LED register)
//   o_count_enabled   registered: RUN or RUN_SPLIT
//   o_split           registered: RUN_SPLIT or PAUSE_SPLIT
//   o_init_regs       registered: high during reset and for one cycle after clr
// -----------------------------------------------------------------------------
module sw_channel_fsm
    import stopwatch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_trig,
    input  logic      i_split,
    input  logic      i_clr,
    output sw_state_e o_state_nxt,
    output logic      o_count_enabled,
    output logic      o_split,
    output logic      o_init_regs
);

    sw_state_e r_state;
    sw_state_e w_state_nxt;

    assign w_state_nxt = sw_next_state(r_state, i_trig, i_split, i_clr);
    assign o_state_nxt = w_state_nxt;

    // Channel state and its outputs, all registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            o_count_enabled <= 1'b0;
            o_split         <= 1'b0;
            o_init_regs     <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            o_count_enabled <= sw_is_counting(w_state_nxt);
            o_split         <= sw_is_split(w_state_nxt);
            o_init_regs     <= i_clr;
        end
    end

endmodule

// File: rtl/dual_sw_scheduler.sv
// -----------------------------------------------------------------------------
// dual_sw_scheduler
// Control sequencer for the two-stopwatch display. Routes debounced trig/split/
// clr pulses to the selected stopwatch channel, keeps the selection register,
// the shared paused-indicator blink counter and the status LED registers.
// Parameters:
//   SEL_RESET   selection after reset (0 = RHS, 1 = LHS)
//   BLINK_HALF  blink half-period in clk cycles
// Configuration macro:
//   SW_TOGGLE_LOCK_EN  when defined, toggle is ignored while the selected
//                      channel holds a split reading
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   trig, split, clr, toggle       one-cycle debounced button pulses
//   sel                            current selection (0 = RHS, 1 = LHS)
//   init_regs_left/right           counter clear pulses
//   count_enabled_left/right       counter enables
//   split_left/right               display freeze lines
//   led_left/right[2:0]            [0] counting/blink, [1] split, [2] selected
// -----------------------------------------------------------------------------
module dual_sw_scheduler
    import stopwatch_pkg::*;
#(
    parameter logic        SEL_RESET  = 1'b0,
    parameter int unsigned BLINK_HALF = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             split,
    input  logic             clr,
    input  logic             toggle,
    output logic             sel,
    output logic             init_regs_left,
    output logic             init_regs_right,
    output logic             count_enabled_left,
    output logic             count_enabled_right,
    output logic             split_left,
    output logic             split_right,
    output logic [LED_W-1:0] led_left,
    output logic [LED_W-1:0] led_right
);

    localparam int unsigned          BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic               r_sel;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink;
    logic [LED_W-1:0]   r_led_left;
    logic [LED_W-1:0]   r_led_right;

    logic               w_toggle_ok;
    logic               w_sel_nxt;
    logic               w_blink_wrap;
    logic               w_blink_nxt;
    sw_state_e          w_left_nxt;
    sw_state_e          w_right_nxt;

    // Events go to the selection held before this edge, even if toggle flips it now.
    sw_channel_fsm u_fsm_left (
        .clk             (clk),
        .reset           (reset),
        .i_trig          (trig  &  r_sel),
        .i_split         (split &  r_sel),
        .i_clr           (clr   &  r_sel),
        .o_state_nxt     (w_left_nxt),
        .o_count_enabled (count_enabled_left),
        .o_split         (split_left),
        .o_init_regs     (init_regs_left)
    );

    sw_channel_fsm u_fsm_right (
        .clk             (clk),
        .reset           (reset),
        .i_trig          (trig  & ~r_sel),
        .i_split         (split & ~r_sel),
        .i_clr           (clr   & ~r_sel),
        .o_state_nxt     (w_right_nxt),
        .o_count_enabled (count_enabled_right),
        .o_split         (split_right),
        .o_init_regs     (init_regs_right)
    );

`ifdef SW_TOGGLE_LOCK_EN
    // The registered split line tells whether the selected channel is frozen.
    assign w_toggle_ok = toggle & ~(r_sel ? split_left : split_right);
`else
    assign w_toggle_ok = toggle;
`endif

    assign w_sel_nxt    = r_sel ^ w_toggle_ok;
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_blink_nxt  = w_blink_wrap ? ~r_blink : r_blink;

    // Selection, shared blink counter and LED words built from next-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sel       <= SEL_RESET;
            r_blink_cnt <= {BLINK_W{1'b0}};
            r_blink     <= 1'b0;
            r_led_left  <= sw_led_word(ST_IDLE, SEL_RESET, 1'b0);
            r_led_right <= sw_led_word(ST_IDLE, ~SEL_RESET, 1'b0);
        end else begin
            r_sel       <= w_sel_nxt;
            r_blink_cnt <= w_blink_wrap ? {BLINK_W{1'b0}} : (r_blink_cnt + BLINK_W'(1));
            r_blink     <= w_blink_nxt;
            r_led_left  <= sw_led_word(w_left_nxt, w_sel_nxt, w_blink_nxt);
            r_led_right <= sw_led_word(w_right_nxt, ~w_sel_nxt, w_blink_nxt);
        end
    end

    assign sel       = r_sel;
    assign led_left  = r_led_left;
    assign led_right = r_led_right;

endmodule

// File: tb/tb_dual_sw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dual_sw_scheduler
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized pulses, all compared against a behavioural stopwatch model that
// tracks each channel as {started, running, frozen} flags.
// -----------------------------------------------------------------------------
module tb_dual_sw_scheduler;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trig = 1'b0;
    logic       split = 1'b0;
    logic       clr = 1'b0;
    logic       toggle = 1'b0;
    logic       sel;
    logic       init_regs_left, init_regs_right;
    logic       count_enabled_left, count_enabled_right;
    logic       split_left, split_right;
    logic [2:0] led_left, led_right;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dual_sw_scheduler #(
        .SEL_RESET  (1'b0),
        .BLINK_HALF (HALF)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .trig                (trig),
        .split               (split),
        .clr                 (clr),
        .toggle              (toggle),
        .sel                 (sel),
        .init_regs_left      (init_regs_left),
        .init_regs_right     (init_regs_right),
        .count_enabled_left  (count_enabled_left),
        .count_enabled_right (count_enabled_right),
        .split_left          (split_left),
        .split_right         (split_right),
        .led_left            (led_left),
        .led_right           (led_right)
    );

    // Reference model; index 0 = RHS, 1 = LHS (same as the sel value).
    bit m_started[2];
    bit m_run[2];
    bit m_frz[2];
    bit m_init[2];
    bit m_sel;
    int m_edges;

    task automatic model_edge(input bit rst, input bit t, input bit s, input bit c, input bit g);
        int k;
        bit lock;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_started[i] = 1'b0; m_run[i] = 1'b0; m_frz[i] = 1'b0; m_init[i] = 1'b1;
            end
            m_sel   = 1'b0;
            m_edges = 0;
        end else begin
            k    = int'(m_sel);
            lock = 1'b0;
`ifdef SW_TOGGLE_LOCK_EN
            lock = m_frz[k];
`endif
            m_init[0] = 1'b0;
            m_init[1] = 1'b0;
            if (c) begin
                m_started[k] = 1'b0; m_run[k] = 1'b0; m_frz[k] = 1'b0; m_init[k] = 1'b1;
            end else if (t) begin
                if (!m_started[k]) begin
                    m_started[k] = 1'b1;
                    m_run[k]     = 1'b1;
                end else begin
                    m_run[k] = !m_run[k];
                end
            end else if (s) begin
                if (m_run[k]) m_frz[k] = !m_frz[k];
                else if (m_frz[k]) m_frz[k] = 1'b0;
            end
            if (g && !lock) m_sel = !m_sel;
            m_edges++;
        end
    endtask

    function automatic logic [2:0] model_led(input int k);
        bit phase;
        bit paused;
        phase  = ((m_edges / HALF) % 2) == 1;
        paused = m_started[k] && !m_run[k];
        return {m_sel == bit'(k), m_frz[k], m_run[k] | (paused & phase)};
    endfunction

    task automatic check_vec(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %013b expected %013b (sel,initL,initR,ceL,ceR,spL,spR,ledL,ledR)",
                     name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare after it.
    task automatic step(input bit rst, input bit t, input bit s, input bit c, input bit g,
                        input string name);
        logic [12:0] act;
        logic [12:0] exp;
        reset = rst; trig = t; split = s; clr = c; toggle = g;
        @(posedge clk);
        model_edge(rst, t, s, c, g);
        #1;
        act = {sel, init_regs_left, init_regs_right, count_enabled_left, count_enabled_right,
               split_left, split_right, led_left, led_right};
        exp = {m_sel, m_init[1], m_init[0], m_run[1], m_run[0], m_frz[1], m_frz[0],
               model_led(1), model_led(0)};
        check_vec(name, act, exp);
    endtask

    typedef struct {
        bit t; bit s; bit c; bit g;
        bit ce_r; bit ce_l; bit sp_r; bit sp_l; bit sel;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic exp_sel;

        // Directed vectors from an idle, RHS-selected start.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // RHS RUN
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // RUN_SPLIT
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // PAUSE_SPLIT
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // PAUSE
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // split ignored
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // RUN
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // select LHS
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // LHS RUN too
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // clr wins, sel flips
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // trig beats split
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // clear RHS

        // Reset held three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
            check_bit("init_left_in_reset", init_regs_left, 1'b1);
            check_bit("init_right_in_reset", init_regs_right, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_release");
        check_bit("init_right_after_release", init_regs_right, 1'b0);
        check_bit("sel_after_reset", sel, 1'b0);

        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].t, tbl[i].s, tbl[i].c, tbl[i].g, $sformatf("tbl_model[%0d]", i));
            check_vec($sformatf("tbl_vec[%0d]", i),
                      {8'd0, count_enabled_right, count_enabled_left, split_right, split_left, sel},
                      {8'd0, tbl[i].ce_r, tbl[i].ce_l, tbl[i].sp_r, tbl[i].sp_l, tbl[i].sel});
            if (i == 8) check_bit("init_left_pulse_on_clr", init_regs_left, 1'b1);
            if (i == 9) check_bit("init_left_pulse_drops", init_regs_left, 1'b0);
        end

        // RHS paused: LED blink phase checked by the model over several half-periods.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "blink_start");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "blink_pause");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "blink_idle");

        // Toggle while RHS holds a split reading.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "lock_clr");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "lock_run");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "lock_split");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "lock_toggle");
`ifdef SW_TOGGLE_LOCK_EN
        exp_sel = 1'b0;
`else
        exp_sel = 1'b1;
`endif
        check_bit("sel_after_split_toggle", sel, exp_sel);

        // Randomized pulses with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5) == 0,
                 "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
